// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler: shares one leaky integrate-and-fire datapath across
// N_NEURONS neurons. Each start runs one timestep. Every neuron fetches its
// input current over valid/ready, then leak, integrate and fire/reset are
// applied in a single UPDATE cycle.
module lif_step_scheduler #(
   parameter  int N_NEURONS = 4,
   parameter  int V_W       = 8,
   localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ena_i,
   input  logic                 start_i,
   input  logic                 cur_valid_i,
   output logic                 cur_ready_o,
   input  logic [V_W-1:0]       cur_data_i,
   output logic [IDX_W-1:0]     cur_idx_o,
   input  logic                 thr_we_i,
   input  logic [V_W-1:0]       thr_data_i,
   input  logic                 leak_we_i,
   input  logic [2:0]           leak_data_i,
   output logic [N_NEURONS-1:0] spikes_o,
   output logic [V_W-1:0]       v_mon_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_UPDATE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
   localparam logic [V_W-1:0]   THR_RST  = V_W'(1) << (V_W - 1);
   localparam logic [2:0]       LEAK_RST = 3'd2;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q;
   logic [N_NEURONS-1:0][V_W-1:0]   mem_q;
   logic [V_W-1:0]                  cur_q;
   // Programmable registers plus the copies frozen for the running timestep
   logic [V_W-1:0]                  thr_q, thr_w_q;
   logic [2:0]                      leak_q, leak_w_q;
   logic [N_NEURONS-1:0]            shadow_q, shadow_nx;
   logic [N_NEURONS-1:0]            spikes_q;
   logic [V_W-1:0]                  v_mon_q;

   logic                            start_acc, hs, upd, last;
   logic [V_W-1:0]                  v_old, v_leak, v_sat;
   logic [V_W:0]                    v_sum;
   logic                            fire;

   // Qualified events; ena low freezes everything
   always_comb begin
      start_acc = ena_i && (state_q == S_IDLE) && start_i;
      hs        = ena_i && (state_q == S_FETCH) && cur_valid_i;
      upd       = ena_i && (state_q == S_UPDATE);
      last      = (idx_q == LAST_IDX);
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state: one FETCH/UPDATE pair per neuron, then a single DONE cycle
   always_comb begin
      state_d = state_q;
      if (ena_i) begin
         case (state_q)
            S_IDLE:   if (start_i) state_d = S_FETCH;
            S_FETCH:  if (cur_valid_i) state_d = S_UPDATE;
            S_UPDATE: state_d = last ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs; done is masked by ena so a stalled DONE cycle does not pulse
   always_comb begin
      cur_ready_o = (state_q == S_FETCH) && ena_i;
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE) && ena_i;
   end

   // Neuron index: walks 0..N-1 and wraps to 0 on the final update
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        idx_q <= '0;
      else if (start_acc) idx_q <= '0;
      else if (upd)       idx_q <= last ? '0 : idx_q + IDX_W'(1);
   end

   // Programmable threshold and leak shift, writable in any state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         thr_q  <= THR_RST;
         leak_q <= LEAK_RST;
      end else if (ena_i) begin
         if (thr_we_i)  thr_q  <= thr_data_i;
         if (leak_we_i) leak_q <= leak_data_i;
      end
   end

   // Working copies taken from the old register values at the start edge, so
   // a same-cycle write only lands in the following timestep
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         thr_w_q  <= THR_RST;
         leak_w_q <= LEAK_RST;
      end else if (start_acc) begin
         thr_w_q  <= thr_q;
         leak_w_q <= leak_q;
      end
   end

   // Input current is captured only on the handshake edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  cur_q <= '0;
      else if (hs)  cur_q <= cur_data_i;
   end

   // Leak/integrate in V_W+1 bits; the leak term never exceeds v so no underflow
   always_comb begin
      v_old  = mem_q[idx_q];
      v_leak = v_old >> leak_w_q;
      v_sum  = {1'b0, v_old} - {1'b0, v_leak} + {1'b0, cur_q};
      v_sat  = v_sum[V_W] ? {V_W{1'b1}} : v_sum[V_W-1:0];
      fire   = (v_sat >= thr_w_q);
      shadow_nx        = shadow_q;
      shadow_nx[idx_q] = fire;
   end

   // Membrane write-back, monitor, and spike collection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         v_mon_q  <= '0;
         shadow_q <= '0;
         spikes_q <= '0;
      end else if (upd) begin
         mem_q[idx_q] <= fire ? '0 : v_sat;
         v_mon_q      <= v_sat;
         shadow_q     <= shadow_nx;
         if (last) spikes_q <= shadow_nx;
      end
   end

   assign cur_idx_o = idx_q;
   assign spikes_o  = spikes_q;
   assign v_mon_o   = v_mon_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Bench for lif_step_scheduler: a table of timesteps with spec-derived expected
// values, a reset-mid-step sequence, then random timesteps against a model.
module tb_lif_step_scheduler;
   localparam int N = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       ena_i = 1'b1;
   logic       start_i = 1'b0;
   logic       cur_valid_i = 1'b0;
   logic       cur_ready_o;
   logic [7:0] cur_data_i = '0;
   logic [1:0] cur_idx_o;
   logic       thr_we_i = 1'b0;
   logic [7:0] thr_data_i = '0;
   logic       leak_we_i = 1'b0;
   logic [2:0] leak_data_i = '0;
   logic [3:0] spikes_o;
   logic [7:0] v_mon_o;
   logic       busy_o;
   logic       done_o;

   lif_step_scheduler #(.N_NEURONS(N), .V_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .start_i(start_i),
      .cur_valid_i(cur_valid_i), .cur_ready_o(cur_ready_o), .cur_data_i(cur_data_i),
      .cur_idx_o(cur_idx_o), .thr_we_i(thr_we_i), .thr_data_i(thr_data_i),
      .leak_we_i(leak_we_i), .leak_data_i(leak_data_i), .spikes_o(spikes_o),
      .v_mon_o(v_mon_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: membranes as plain integers, config as values
   int         m_mem [N];
   int         m_thr, m_leak;
   int         st_cur [N];
   int         st_ev [N];
   logic [3:0] st_espk;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_mem[i] = 0;
      m_thr  = 128;
      m_leak = 2;
   endfunction

   // One timestep with the config in force at its start
   function automatic void model_step();
      for (int i = 0; i < N; i++) begin
         int v, nv;
         v  = m_mem[i];
         nv = v - (v / (1 << m_leak)) + st_cur[i];
         if (nv > 255) nv = 255;
         st_ev[i] = nv;
         if (nv >= m_thr) begin
            st_espk[i] = 1'b1;
            m_mem[i]   = 0;
         end else begin
            st_espk[i] = 1'b0;
            m_mem[i]   = nv;
         end
      end
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic write_cfg(input int thr, input int leak);
      @(negedge clk_i);
      thr_we_i = 1'b1; thr_data_i = 8'(thr);
      leak_we_i = 1'b1; leak_data_i = 3'(leak);
      m_thr = thr; m_leak = leak;
      @(posedge clk_i);
      @(negedge clk_i);
      thr_we_i = 1'b0; leak_we_i = 1'b0;
   endtask

   // Runs one timestep feeding st_cur; checks v_mon per neuron, cur_idx,
   // latency, busy length, spikes and the return to idle.
   //  st_at/st_n : hold cur_valid low st_n cycles when fetching neuron st_at
   //  wthr/wwhen : threshold write (wthr>=0) at start cycle (0) or cycle wwhen
   //  sb         : pulse start while busy
   //  en_n       : drop ena for en_n cycles when neuron 1 is fetched
   task automatic run_step(input int st_at, input int st_n, input int wthr,
                           input int wwhen, input bit sb, input int en_n,
                           input int elat);
      int cnt = 0, n = 0, ph = 0, sl = st_n, el = 0, busy_n = 0;
      bit got = 1'b0, en_used = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1;
      if (wthr >= 0 && wwhen == 0) begin
         thr_we_i = 1'b1; thr_data_i = 8'(wthr); m_thr = wthr;
      end
      while (!got && cnt < 100) begin
         @(posedge clk_i);
         cnt++;
         @(negedge clk_i);
         start_i     = sb && (cnt == 3);
         thr_we_i    = 1'b0;
         cur_valid_i = 1'b0;
         if (busy_o) busy_n++;
         if (wthr >= 0 && wwhen == cnt) begin
            thr_we_i = 1'b1; thr_data_i = 8'(wthr); m_thr = wthr;
         end
         if (ph == 2) begin
            chk("v_mon", {24'd0, v_mon_o}, st_ev[n]);
            n++;
            ph = 0;
         end
         if (ph == 1) ph = 2;
         if (done_o) got = 1'b1;
         else if (el > 0) begin
            chk("ready_while_ena_low", {31'd0, cur_ready_o}, 0);
            chk("idx_while_ena_low", {30'd0, cur_idx_o}, 1);
            el--;
            if (el == 0) begin
               ena_i = 1'b1;
               #1;
            end
         end
         if (!got && el == 0 && ph == 0 && n < N && cur_ready_o) begin
            chk("cur_idx", {30'd0, cur_idx_o}, n);
            if (n == 1 && en_n > 0 && !en_used) begin
               en_used = 1'b1; ena_i = 1'b0; el = en_n;
            end else if (n == st_at && sl > 0) begin
               sl--;
            end else begin
               cur_valid_i = 1'b1;
               cur_data_i  = 8'(st_cur[n]);
               ph = 1;
            end
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      chk("latency", cnt, elat);
      chk("busy_cycles", busy_n, elat);
      chk("updates", n, N);
      chk("spikes", {28'd0, spikes_o}, {28'd0, st_espk});
      @(posedge clk_i);
      @(negedge clk_i);
      chk("idle_busy", {31'd0, busy_o}, 0);
      chk("idle_done", {31'd0, done_o}, 0);
      chk("spikes_hold", {28'd0, spikes_o}, {28'd0, st_espk});
   endtask

   // Reset asserted mid-clock during UPDATE of neuron 1
   task automatic abort_mid_step();
      @(negedge clk_i);
      start_i = 1'b1; cur_valid_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      start_i = 1'b0;
      cur_valid_i = 1'b1; cur_data_i = 8'd7;
      @(posedge clk_i); @(negedge clk_i);
      cur_valid_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      cur_valid_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      cur_valid_i = 1'b0;
      chk("abort_idx", {30'd0, cur_idx_o}, 1);
      chk("abort_busy", {31'd0, busy_o}, 1);
      chk("abort_spikes_before", {28'd0, spikes_o}, 15);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_spikes", {28'd0, spikes_o}, 0);
      chk("rst_v_mon", {24'd0, v_mon_o}, 0);
      chk("rst_done", {31'd0, done_o}, 0);
      chk("rst_busy", {31'd0, busy_o}, 0);
      chk("rst_ready", {31'd0, cur_ready_o}, 0);
      chk("rst_idx", {30'd0, cur_idx_o}, 0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   typedef struct {
      bit         rst;
      bit         cfg;
      int         thr;
      int         leak;
      int         cur;
      int         st_at;
      int         st_n;
      int         wthr;
      int         wwhen;
      bit         sb;
      int         en_n;
      int         ev;
      logic [3:0] espk;
      int         lat;
   } vec_t;

   vec_t tbl [14];

   initial begin
      //           rst cfg thr leak cur st_at st_n wthr wwhen sb en_n  ev   espk  lat
      tbl[0]  = '{1'b1, 1'b1, 100, 2,  40,  -1, 0,  -1,  0, 1'b0, 0,  40, 4'h0,  9};
      tbl[1]  = '{1'b0, 1'b0,   0, 0,  40,  -1, 0,  -1,  0, 1'b1, 0,  70, 4'h0,  9};
      tbl[2]  = '{1'b0, 1'b0,   0, 0,  40,   2, 5,  -1,  0, 1'b0, 0,  93, 4'h0, 14};
      tbl[3]  = '{1'b0, 1'b0,   0, 0,  40,  -1, 0,  -1,  0, 1'b0, 0, 110, 4'hF,  9};
      tbl[4]  = '{1'b0, 1'b0,   0, 0,  40,  -1, 0,  -1,  0, 1'b0, 3,  40, 4'h0, 12};
      tbl[5]  = '{1'b1, 1'b1, 255, 7, 200,  -1, 0,  -1,  0, 1'b0, 0, 200, 4'h0,  9};
      tbl[6]  = '{1'b0, 1'b0,   0, 0, 200,  -1, 0,  -1,  0, 1'b0, 0, 255, 4'hF,  9};
      tbl[7]  = '{1'b1, 1'b1,   0, 2,   0,  -1, 0,  -1,  0, 1'b0, 0,   0, 4'hF,  9};
      tbl[8]  = '{1'b0, 1'b0,   0, 0,   5,  -1, 0,  -1,  0, 1'b0, 0,   5, 4'hF,  9};
      // after the mid-step reset: default thr=128, leak=2, membranes from 0
      tbl[9]  = '{1'b0, 1'b0,   0, 0, 100,  -1, 0,  -1,  0, 1'b0, 0, 100, 4'h0,  9};
      tbl[10] = '{1'b0, 1'b0,   0, 0, 100,  -1, 0,  -1,  0, 1'b0, 0, 175, 4'hF,  9};
      // thr writes at start edge and mid-step apply only to the next step
      tbl[11] = '{1'b1, 1'b1, 100, 2,  60,  -1, 0,  10,  0, 1'b0, 0,  60, 4'h0,  9};
      tbl[12] = '{1'b0, 1'b0,   0, 0,   0,  -1, 0, 200,  4, 1'b0, 0,  45, 4'hF,  9};
      tbl[13] = '{1'b0, 1'b0,   0, 0, 150,  -1, 0,  -1,  0, 1'b0, 0, 150, 4'h0,  9};

      model_reset();
      #3;
      chk("por_busy", {31'd0, busy_o}, 0);
      chk("por_spikes", {28'd0, spikes_o}, 0);
      chk("por_v_mon", {24'd0, v_mon_o}, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 14; i++) begin
         if (i == 9) abort_mid_step();
         if (tbl[i].rst) do_reset();
         if (tbl[i].cfg) write_cfg(tbl[i].thr, tbl[i].leak);
         for (int k = 0; k < N; k++) begin
            st_cur[k] = tbl[i].cur;
            st_ev[k]  = tbl[i].ev;
         end
         st_espk = tbl[i].espk;
         run_step(tbl[i].st_at, tbl[i].st_n, tbl[i].wthr, tbl[i].wwhen,
                  tbl[i].sb, tbl[i].en_n, tbl[i].lat);
      end

      // Random timesteps against the model
      do_reset();
      for (int s = 0; s < 40; s++) begin
         int sa, sn;
         if ($urandom_range(0, 3) == 0)
            write_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
         for (int k = 0; k < N; k++) st_cur[k] = int'($urandom_range(0, 120));
         sa = int'($urandom_range(0, N - 1));
         sn = int'($urandom_range(0, 4));
         model_step();
         run_step(sa, sn, -1, 0, 1'b0, 0, 9 + sn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
